// File: rtl/jogo_sequencia_param_if.sv
// ----------------------------------------------------------------------------
// jogo_sequencia_param_if
//
// Signal bundle between the sequence-memory game controller and the board
// (switches, LEDs, debug displays).
//
// Parameters:
//   N      number of switches / width of a sequence entry
//   DEPTH  maximum sequence length (AW = address width derived from it)
//
// Signals:
//   iniciar      board -> game  start / restart request (level)
//   modo         board -> game  0 = fixed length, 1 = progressive rounds
//   chaves       board -> game  player switches, N bits
//   acertou      game -> board  game won
//   errou        game -> board  wrong play
//   timeout      game -> board  play not made in time
//   pronto       game -> board  game finished, any outcome
//   leds         game -> board  last registered play, N bits
//   db_estado    game -> board  state code, 4 bits
//   db_contagem  game -> board  current address within the round, AW bits
//   db_rodada    game -> board  current round limit, AW bits
//   db_jogada    game -> board  one-cycle play-detect pulse
//
// Modports:
//   master  board / testbench side
//   slave   game controller side
// ----------------------------------------------------------------------------
interface jogo_sequencia_param_if #(
    parameter int N     = 4,
    parameter int DEPTH = 16
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          iniciar;
    logic          modo;
    logic [N-1:0]  chaves;
    logic          acertou;
    logic          errou;
    logic          timeout;
    logic          pronto;
    logic [N-1:0]  leds;
    logic [3:0]    db_estado;
    logic [AW-1:0] db_contagem;
    logic [AW-1:0] db_rodada;
    logic          db_jogada;

    modport master (
        output iniciar,
        output modo,
        output chaves,
        input  acertou,
        input  errou,
        input  timeout,
        input  pronto,
        input  leds,
        input  db_estado,
        input  db_contagem,
        input  db_rodada,
        input  db_jogada
    );

    modport slave (
        input  iniciar,
        input  modo,
        input  chaves,
        output acertou,
        output errou,
        output timeout,
        output pronto,
        output leds,
        output db_estado,
        output db_contagem,
        output db_rodada,
        output db_jogada
    );
endinterface

// File: rtl/jogo_sequencia_param.sv
// ----------------------------------------------------------------------------
// jogo_sequencia_param
//
// Parametrised sequence-memory game controller. The player reproduces a
// stored sequence of one-hot patterns on N switches, either the whole
// sequence at once (fixed mode) or in growing rounds (progressive mode).
// Entry i of the built-in sequence is 1 << (i mod N).
//
// Parameters:
//   N               number of switches / entry width       (default 4)
//   DEPTH           maximum sequence length                (default 16)
//   TIMEOUT_CYCLES  cycles allowed per play in espera      (default 3000)
//
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous, active-low; clears all state immediately
//   bus     jogo_sequencia_param_if.slave (iniciar, modo, chaves in;
//           acertou, errou, timeout, pronto, leds, db_* out)
//
// Configuration macro:
//   JOGO_TIMEOUT_EN  defined: per-play timer, fim_timeout state and timeout
//                    output are built. Undefined: espera waits forever and
//                    timeout is tied to 0.
//
// State codes on db_estado: inicial 0, preparacao 1, espera 2, compara 4,
// proximo 5, proxima_rodada 6, fim_acertou A, fim_timeout D, fim_errou E.
// ----------------------------------------------------------------------------
module jogo_sequencia_param #(
    parameter int N              = 4,
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 3000
) (
    input logic                   clock,
    input logic                   reset,
    jogo_sequencia_param_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    if (N < 1 || DEPTH < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("jogo_sequencia_param: needs N >= 1, DEPTH >= 2, TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [3:0] {
        inicial        = 4'h0,
        preparacao     = 4'h1,
        espera         = 4'h2,
        compara        = 4'h4,
        proximo        = 4'h5,
        proxima_rodada = 4'h6,
        fim_acertou    = 4'hA,
        fim_timeout    = 4'hD,
        fim_errou      = 4'hE
    } estado_t;

    estado_t       estado;
    estado_t       estado_next;

    logic [N-1:0]  chaves_d;
    logic [N-1:0]  leds;
    logic [AW-1:0] contagem;
    logic [AW-1:0] rodada;
    logic [N-1:0]  mem_dado;
    logic          jogada;

    // Built-in sequence: a walking one that wraps every N entries.
    function automatic logic [N-1:0] rom_entry(input logic [AW-1:0] addr);
        logic [N-1:0] one;
        int unsigned  idx;
        one    = '0;
        one[0] = 1'b1;
        idx    = 32'(addr) % 32'(N);
        return one << idx;
    endfunction

    assign mem_dado = rom_entry(contagem);

    // Rising edge of "any switch on": holding switches yields a single play,
    // and all switches must drop to 0 before the next play can register.
    assign jogada = (|bus.chaves) & ~(|chaves_d);

`ifdef JOGO_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else begin
            case (estado)
                preparacao,
                proximo,
                proxima_rodada: timer <= '0;
                espera:         timer <= timer + 1'b1;
                default:        timer <= timer;
            endcase
        end
    end
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= inicial;
        end else begin
            estado <= estado_next;
        end
    end

    // Next-state logic
    always_comb begin
        estado_next = estado;
        case (estado)
            inicial: begin
                if (bus.iniciar) estado_next = preparacao;
            end
            preparacao: begin
                estado_next = espera;
            end
            espera: begin
                // A play arriving in the same cycle as the timer limit wins.
                if (jogada) begin
                    estado_next = compara;
                end
`ifdef JOGO_TIMEOUT_EN
                else if (timer == TIMER_LAST) begin
                    estado_next = fim_timeout;
                end
`endif
            end
            compara: begin
                if (leds != mem_dado) begin
                    estado_next = fim_errou;
                end else if (contagem < rodada) begin
                    estado_next = proximo;
                end else if (rodada < LAST) begin
                    estado_next = proxima_rodada;
                end else begin
                    estado_next = fim_acertou;
                end
            end
            proximo,
            proxima_rodada: begin
                estado_next = espera;
            end
            fim_acertou,
            fim_errou,
            fim_timeout: begin
                if (bus.iniciar) estado_next = preparacao;
            end
            default: begin
                estado_next = inicial;
            end
        endcase
    end

    // Datapath registers. contagem only advances while below rodada, and
    // rodada only while below LAST, so neither can wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chaves_d <= '0;
            leds     <= '0;
            contagem <= '0;
            rodada   <= '0;
        end else begin
            chaves_d <= bus.chaves;
            case (estado)
                preparacao: begin
                    contagem <= '0;
                    leds     <= '0;
                    rodada   <= bus.modo ? '0 : LAST;
                end
                espera: begin
                    if (jogada) leds <= bus.chaves;
                end
                proximo: begin
                    contagem <= contagem + 1'b1;
                end
                proxima_rodada: begin
                    rodada   <= rodada + 1'b1;
                    contagem <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Moore outputs
    assign bus.acertou     = (estado == fim_acertou);
    assign bus.errou       = (estado == fim_errou);
`ifdef JOGO_TIMEOUT_EN
    assign bus.timeout     = (estado == fim_timeout);
`else
    assign bus.timeout     = 1'b0;
`endif
    assign bus.pronto      = (estado == fim_acertou) || (estado == fim_errou) ||
                             (estado == fim_timeout);
    assign bus.leds        = leds;
    assign bus.db_estado   = estado;
    assign bus.db_contagem = contagem;
    assign bus.db_rodada   = rodada;
    assign bus.db_jogada   = jogada;

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// ----------------------------------------------------------------------------
// tb_jogo_sequencia_param
//
// Directed bench for jogo_sequencia_param with N=4, DEPTH=4,
// TIMEOUT_CYCLES=20. Inputs are driven and outputs sampled 1 time unit
// after each rising clock edge. Timeout expectations follow the
// JOGO_TIMEOUT_EN macro.
// ----------------------------------------------------------------------------
module tb_jogo_sequencia_param;
    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int TO    = 20;

    logic clock;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    jogo_sequencia_param_if #(.N(N), .DEPTH(DEPTH)) bus_if ();

    jogo_sequencia_param #(
        .N              (N),
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_game(input logic m);
        bus_if.iniciar = 1'b1;
        bus_if.modo    = m;
        tick();
        check("prep_state", 32'(bus_if.db_estado), 32'h1);
        bus_if.iniciar = 1'b0;
        tick();
        check("espera_state", 32'(bus_if.db_estado), 32'h2);
    endtask

    // Make one play and check the state that follows compara.
    task automatic play(input string tag, input logic [3:0] val, input logic [3:0] exp_state);
        bus_if.chaves = val;
        tick();
        check({tag, "_compara"}, 32'(bus_if.db_estado), 32'h4);
        check({tag, "_leds"}, 32'(bus_if.leds), 32'(val));
        bus_if.chaves = '0;
        tick();
        check({tag, "_next"}, 32'(bus_if.db_estado), 32'(exp_state));
        if (exp_state == 4'h5 || exp_state == 4'h6) tick();
    endtask

    task automatic async_reset();
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        @(posedge clock);
        #3;
        reset = 1'b1;
    endtask

    initial begin
        int pulses;
        reset          = 1'b0;
        bus_if.iniciar = 1'b0;
        bus_if.modo    = 1'b0;
        bus_if.chaves  = '0;
        #2;
        check("rst_estado", 32'(bus_if.db_estado), 32'h0);
        check("rst_outs", {bus_if.acertou, bus_if.errou, bus_if.timeout, bus_if.pronto},
              32'h0);
        check("rst_leds", 32'(bus_if.leds), 32'h0);
        #11;
        reset = 1'b1;
        tick();
        check("idle_estado", 32'(bus_if.db_estado), 32'h0);

        // Fixed mode, full correct sequence
        start_game(1'b0);
        check("fix_rodada", 32'(bus_if.db_rodada), 32'h3);
        play("fix_p0", 4'b0001, 4'h5);
        play("fix_p1", 4'b0010, 4'h5);
        play("fix_p2", 4'b0100, 4'h5);
        play("fix_p3", 4'b1000, 4'hA);
        check("fix_win", {bus_if.acertou, bus_if.errou, bus_if.pronto}, 32'b101);
        check("fix_win_leds", 32'(bus_if.leds), 32'b1000);
        tick();
        check("fix_win_held", 32'(bus_if.db_estado), 32'hA);

        // Fixed mode, wrong last play
        start_game(1'b0);
        check("fix2_leds_clr", 32'(bus_if.leds), 32'h0);
        play("err_p0", 4'b0001, 4'h5);
        play("err_p1", 4'b0010, 4'h5);
        play("err_p2", 4'b0100, 4'h5);
        play("err_p3", 4'b0001, 4'hE);
        check("err_flags", {bus_if.acertou, bus_if.errou, bus_if.pronto}, 32'b011);
        check("err_contagem", 32'(bus_if.db_contagem), 32'h3);
        check("err_leds", 32'(bus_if.leds), 32'b0001);

        // Multi-hot play is always wrong
        start_game(1'b0);
        play("multihot", 4'b0011, 4'hE);

        // Progressive mode, all rounds correct (10 plays)
        start_game(1'b1);
        check("prog_rodada0", 32'(bus_if.db_rodada), 32'h0);
        play("r0_p0", 4'b0001, 4'h6);
        play("r1_p0", 4'b0001, 4'h5);
        play("r1_p1", 4'b0010, 4'h6);
        check("prog_rodada2", 32'(bus_if.db_rodada), 32'h2);
        check("prog_contagem0", 32'(bus_if.db_contagem), 32'h0);
        play("r2_p0", 4'b0001, 4'h5);
        play("r2_p1", 4'b0010, 4'h5);
        play("r2_p2", 4'b0100, 4'h6);
        play("r3_p0", 4'b0001, 4'h5);
        play("r3_p1", 4'b0010, 4'h5);
        play("r3_p2", 4'b0100, 4'h5);
        play("r3_p3", 4'b1000, 4'hA);
        check("prog_win", {bus_if.acertou, bus_if.errou, bus_if.pronto}, 32'b101);
        check("prog_win_rodada", 32'(bus_if.db_rodada), 32'h3);

        // Progressive mode, wrong second play in round with limit 2
        start_game(1'b1);
        play("pe_r0_p0", 4'b0001, 4'h6);
        play("pe_r1_p0", 4'b0001, 4'h5);
        play("pe_r1_p1", 4'b0010, 4'h6);
        play("pe_r2_p0", 4'b0001, 4'h5);
        play("pe_r2_p1", 4'b0100, 4'hE);
        check("pe_errou", 32'(bus_if.errou), 32'h1);
        check("pe_rodada", 32'(bus_if.db_rodada), 32'h2);

        // Held switches give one play only
        start_game(1'b0);
        pulses = 0;
        bus_if.chaves = 4'b0001;
        #1;
        if (bus_if.db_jogada) pulses++;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus_if.db_jogada) pulses++;
        end
        check("hold_pulses", 32'(pulses), 32'h1);
        check("hold_contagem", 32'(bus_if.db_contagem), 32'h1);
        check("hold_leds", 32'(bus_if.leds), 32'b0001);

        // Asynchronous reset between clock edges
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("ares_estado", 32'(bus_if.db_estado), 32'h0);
        check("ares_outs", {bus_if.acertou, bus_if.errou, bus_if.timeout, bus_if.pronto},
              32'h0);
        check("ares_regs", {bus_if.leds, bus_if.db_contagem, bus_if.db_rodada}, 32'h0);
        @(posedge clock);
        #3;
        reset = 1'b1;
        bus_if.chaves = '0;
        tick();
        start_game(1'b0);
        play("after_rst", 4'b0001, 4'h5);
        check("after_rst_cont", 32'(bus_if.db_contagem), 32'h1);
        check("after_rst_state", 32'(bus_if.db_estado), 32'h2);

        // Timeout (or indefinite wait without the timer)
        async_reset();
        tick();
        start_game(1'b0);
        repeat (TO - 1) tick();
        check("to_before", 32'(bus_if.db_estado), 32'h2);
        tick();
`ifdef JOGO_TIMEOUT_EN
        check("to_state", 32'(bus_if.db_estado), 32'hD);
        check("to_flags", {bus_if.timeout, bus_if.pronto, bus_if.errou, bus_if.acertou},
              32'b1100);
`else
        repeat (100 - TO) tick();
        check("noto_state", 32'(bus_if.db_estado), 32'h2);
        check("noto_flags", {bus_if.timeout, bus_if.pronto}, 32'b00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
